// File: rtl/i2c_reg_sequencer_if.sv
// Command/response and byte-engine handshake bundle for i2c_reg_sequencer.
// master = the sequencer, slave = command source plus byte engine.
interface i2c_reg_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [6:0] cmd_dev;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic       m_take_bus;
  logic [7:0] m_tx_data;
  logic       m_tx_valid;
  logic       m_tx_ready;
  logic [7:0] m_rx_data;
  logic       m_rx_valid;
  logic       m_rx_ready;
  logic       m_ack_lost;
  logic       m_bus_busy;

  modport master (
    input  cmd_valid, cmd_rw, cmd_dev, cmd_reg, cmd_wdata, rsp_ready,
    input  m_tx_ready, m_rx_data, m_rx_valid, m_ack_lost, m_bus_busy,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output m_take_bus, m_tx_data, m_tx_valid, m_rx_ready
  );

  modport slave (
    output cmd_valid, cmd_rw, cmd_dev, cmd_reg, cmd_wdata, rsp_ready,
    output m_tx_ready, m_rx_data, m_rx_valid, m_ack_lost, m_bus_busy,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  m_take_bus, m_tx_data, m_tx_valid, m_rx_ready
  );
endinterface

// File: rtl/i2c_reg_sequencer.sv
// Single-register I2C read/write sequencer driving a byte-level master engine.
// Reads use write(reg), STOP, gap, then a fresh START with the read address.
module i2c_reg_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter int unsigned GAP_CYC     = 16
) (
  input logic                clk,
  input logic                rst,
  i2c_reg_sequencer_if.master bus_io
);

  typedef enum logic [3:0] {
    StIdle, StStart, StTxDev, StTxReg, StTxData, StAckWait,
    StStop1, StStartR, StTxDevR, StRx, StStop, StResp
  } state_e;

  typedef enum logic [1:0] {ByteDev, ByteReg, ByteData, ByteDevR} byte_e;

  localparam logic [1:0] ErrOk      = 2'd0;
  localparam logic [1:0] ErrDevNack = 2'd1;
  localparam logic [1:0] ErrRegNack = 2'd2;
  localparam logic [1:0] ErrTimeout = 2'd3;

  state_e      state_q;
  byte_e       byte_q;
  logic        rw_q;
  logic [6:0]  dev_q;
  logic [7:0]  reg_q;
  logic [7:0]  wdata_q;
  logic [1:0]  err_q;
  logic [31:0] cnt_q;
  logic [31:0] gap_q;
  logic        cmd_ready_q;
  logic        rsp_valid_q;
  logic [7:0]  rsp_rdata_q;
  logic        take_bus_q;
  logic        tx_valid_q;
  logic [7:0]  tx_data_q;
  logic        rx_ready_q;

  logic        counted;
  logic        timeout;
  logic        ack_seen;
  logic [1:0]  nack_code;

  function automatic byte_e byte_of(state_e s);
    case (s)
      StTxDev:  return ByteDev;
      StTxReg:  return ByteReg;
      StTxData: return ByteData;
      default:  return ByteDevR;
    endcase
  endfunction

  always_comb begin
    counted   = state_q inside {StTxDev, StTxReg, StTxData, StTxDevR, StAckWait,
                                StRx, StStop1, StStop};
    timeout   = counted && (cnt_q >= TIMEOUT_CYC - 32'd1);
    // The ACK of the previous byte is settled once the engine offers its next slot or goes idle.
    ack_seen  = bus_io.m_tx_ready || !bus_io.m_bus_busy;
    nack_code = (byte_q inside {ByteDev, ByteDevR}) ? ErrDevNack : ErrRegNack;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      byte_q      <= ByteDev;
      rw_q        <= 1'b0;
      dev_q       <= '0;
      reg_q       <= '0;
      wdata_q     <= '0;
      err_q       <= ErrOk;
      cnt_q       <= '0;
      gap_q       <= '0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      take_bus_q  <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      rx_ready_q  <= 1'b0;
    end else begin
      cnt_q <= counted ? cnt_q + 32'd1 : '0;
      if (timeout && state_q != StStop) begin
        if (err_q == ErrOk) err_q <= ErrTimeout;
        tx_valid_q <= 1'b0;
        rx_ready_q <= 1'b0;
        take_bus_q <= 1'b0;
        cnt_q      <= '0;
        state_q    <= StStop;
      end else begin
        unique case (state_q)
          StIdle: begin
            cmd_ready_q <= 1'b1;
            if (bus_io.cmd_valid && cmd_ready_q) begin
              rw_q        <= bus_io.cmd_rw;
              dev_q       <= bus_io.cmd_dev;
              reg_q       <= bus_io.cmd_reg;
              wdata_q     <= bus_io.cmd_wdata;
              err_q       <= ErrOk;
              rsp_rdata_q <= '0;
              cmd_ready_q <= 1'b0;
              take_bus_q  <= 1'b1;
              state_q     <= StStart;
            end
          end
          StStart: begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= {dev_q, 1'b0};
            state_q    <= StTxDev;
          end
          StTxDev, StTxReg, StTxData, StTxDevR: begin
            if (bus_io.m_tx_ready) begin
              tx_valid_q <= 1'b0;
              byte_q     <= byte_of(state_q);
              cnt_q      <= '0;
              state_q    <= StAckWait;
            end
          end
          StAckWait: begin
            if (ack_seen) begin
              cnt_q <= '0;
              if (bus_io.m_ack_lost) begin
                if (err_q == ErrOk) err_q <= nack_code;
                take_bus_q <= 1'b0;
                state_q    <= StStop;
              end else begin
                unique case (byte_q)
                  ByteDev: begin
                    tx_valid_q <= 1'b1;
                    tx_data_q  <= reg_q;
                    state_q    <= StTxReg;
                  end
                  ByteReg: begin
                    if (rw_q) begin
                      take_bus_q <= 1'b0;
                      gap_q      <= '0;
                      state_q    <= StStop1;
                    end else begin
                      tx_valid_q <= 1'b1;
                      tx_data_q  <= wdata_q;
                      state_q    <= StTxData;
                    end
                  end
                  ByteData: begin
                    take_bus_q <= 1'b0;
                    state_q    <= StStop;
                  end
                  ByteDevR: begin
                    rx_ready_q <= 1'b1;
                    state_q    <= StRx;
                  end
                  default: state_q <= StStop;
                endcase
              end
            end
          end
          StStop1: begin
            // Gap counting starts at the first idle sample and then runs regardless of busy.
            if (gap_q != '0 || !bus_io.m_bus_busy) begin
              if (gap_q >= GAP_CYC - 32'd1) begin
                take_bus_q <= 1'b1;
                cnt_q      <= '0;
                state_q    <= StStartR;
              end else begin
                gap_q <= gap_q + 32'd1;
              end
            end
          end
          StStartR: begin
            tx_valid_q <= 1'b1;
            tx_data_q  <= {dev_q, 1'b1};
            state_q    <= StTxDevR;
          end
          StRx: begin
            if (bus_io.m_rx_valid) begin
              rsp_rdata_q <= bus_io.m_rx_data;
              rx_ready_q  <= 1'b0;
              take_bus_q  <= 1'b0;
              cnt_q       <= '0;
              state_q     <= StStop;
            end
          end
          StStop: begin
            if (!bus_io.m_bus_busy) begin
              rsp_valid_q <= 1'b1;
              state_q     <= StResp;
            end else if (timeout) begin
              if (err_q == ErrOk) err_q <= ErrTimeout;
              rsp_rdata_q <= '0;
              rsp_valid_q <= 1'b1;
              state_q     <= StResp;
            end
          end
          StResp: begin
            if (bus_io.rsp_ready) begin
              rsp_valid_q <= 1'b0;
              cmd_ready_q <= 1'b1;
              state_q     <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus_io.cmd_ready  = cmd_ready_q;
  assign bus_io.rsp_valid  = rsp_valid_q;
  assign bus_io.rsp_rdata  = rsp_rdata_q;
  assign bus_io.rsp_err    = err_q;
  assign bus_io.m_take_bus = take_bus_q;
  assign bus_io.m_tx_data  = tx_data_q;
  assign bus_io.m_tx_valid = tx_valid_q;
  assign bus_io.m_rx_ready = rx_ready_q;

endmodule
